demux_1a4_reg: RTL and testbench

//   Registered 1-to-4 demultiplexer for WIDTH-bit data words with valid/ready handshakes.

---
 rtl/demux_1a4_reg.sv | 90 +++++++++
 tb/tb_demux_1a4_reg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_1a4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshakes and one holding
// register per output channel; destination from in_sel or a round-robin pointer.

module demux_1a4_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             drain,
  output logic [WIDTH-1:0] data,
  output logic             valid
);
  // A load wins over a drain: the new word replaces the old without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= ld_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end
endmodule

module demux_1a4_reg #(
  parameter int WIDTH   = 8,
  parameter bit RR_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       rr_ptr,
  output logic             busy
);
  localparam int NUM_CH = 4;

  logic [NUM_CH-1:0][WIDTH-1:0] chan_data;
  logic [NUM_CH-1:0]            load;
  logic [1:0]                   rr_q;
  logic [1:0]                   dst;
  logic                         accept;

  assign dst      = RR_MODE ? rr_q : in_sel;
  // Ready looks only at the target channel so a stalled neighbour never blocks.
  assign in_ready = ~out_valid[dst] | out_ready[dst];
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign load[k] = accept & (dst == 2'(k));
    demux_1a4_chan #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .load    (load[k]),
      .ld_data (in_data),
      .drain   (out_ready[k]),
      .data    (chan_data[k]),
      .valid   (out_valid[k])
    );
  end

  if (RR_MODE) begin : g_rr
    // Pointer advances only on accept, so a full target stalls rather than skips.
    always_ff @(posedge clk) begin
      if (rst)         rr_q <= 2'd0;
      else if (accept) rr_q <= rr_q + 2'd1;
    end
  end else begin : g_sel
    assign rr_q = 2'd0;
  end

  assign rr_ptr    = rr_q;
  assign busy      = |out_valid;
  assign out_data0 = chan_data[0];
  assign out_data1 = chan_data[1];
  assign out_data2 = chan_data[2];
  assign out_data3 = chan_data[3];
endmodule

// File: tb/tb_demux_1a4_reg.sv
// Bench for demux_1a4_reg: an explicit-select and a round-robin instance,
// with a scoreboard matching every consumed word against what was sent.

module tb_demux_1a4_reg;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance a: RR_MODE=0, instance b: RR_MODE=1
  logic [7:0] a_data, b_data;
  logic [1:0] a_sel, b_sel;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [7:0] a_o [4];
  logic [7:0] b_o [4];
  logic [3:0] a_ov, b_ov, a_or, b_or;
  logic [1:0] a_rr, b_rr;
  logic       a_busy, b_busy;

  demux_1a4_reg #(.WIDTH(8), .RR_MODE(1'b0)) u_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid),
    .in_ready(a_ready), .out_data0(a_o[0]), .out_data1(a_o[1]), .out_data2(a_o[2]),
    .out_data3(a_o[3]), .out_valid(a_ov), .out_ready(a_or), .rr_ptr(a_rr), .busy(a_busy)
  );

  demux_1a4_reg #(.WIDTH(8), .RR_MODE(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid),
    .in_ready(b_ready), .out_data0(b_o[0]), .out_data1(b_o[1]), .out_data2(b_o[2]),
    .out_data3(b_o[3]), .out_valid(b_ov), .out_ready(b_or), .rr_ptr(b_rr), .busy(b_busy)
  );

  typedef struct {
    int         dut;
    int         ch;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   mrr   = 0;

  // One clock step: record handshakes and consumptions just before the edge.
  task automatic tick();
    #1;
    if (!rst) begin
      if (a_valid && a_ready) sb.push_back('{0, int'(a_sel), a_data});
      if (b_valid && b_ready) begin
        sb.push_back('{1, mrr, b_data});
        mrr = (mrr + 1) % 4;
      end
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 4; k++) begin
          logic       take;
          logic [7:0] od;
          int         idx;
          take = (d == 1) ? (b_ov[k] && b_or[k]) : (a_ov[k] && a_or[k]);
          od   = (d == 1) ? b_o[k] : a_o[k];
          idx  = -1;
          if (take) begin
            foreach (sb[i]) if (idx < 0 && sb[i].dut == d && sb[i].ch == k) idx = i;
            total++;
            if (idx < 0) begin
              bad++;
              $display("FAIL sb_drain dut%0d ch%0d: consumed %h, nothing expected", d, k, od);
            end else begin
              if (od !== sb[idx].data) begin
                bad++;
                $display("FAIL sb_drain dut%0d ch%0d: got %h want %h", d, k, od, sb[idx].data);
              end
              sb.delete(idx);
            end
          end
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      sb.delete();
      mrr = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    a_data = 8'h5A; b_data = 8'hA5; a_sel = 2'd2; b_sel = 2'd1;
    a_or = 4'b0000; b_or = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    #1;
    total++; if ({a_ov, b_ov} !== 8'h00) begin bad++; $display("FAIL reset_valid: got %b want 00000000", {a_ov, b_ov}); end
    total++; if ({a_o[0], a_o[1], a_o[2], a_o[3]} !== 32'h0) begin bad++; $display("FAIL reset_data_a: got %h want 0", {a_o[0], a_o[1], a_o[2], a_o[3]}); end
    total++; if ({b_o[0], b_o[1], b_o[2], b_o[3]} !== 32'h0) begin bad++; $display("FAIL reset_data_b: got %h want 0", {b_o[0], b_o[1], b_o[2], b_o[3]}); end
    total++; if ({a_rr, b_rr} !== 4'h0) begin bad++; $display("FAIL reset_rr: got %b want 0000", {a_rr, b_rr}); end
    total++; if ({a_ready, b_ready} !== 2'b11) begin bad++; $display("FAIL reset_ready: got %b want 11", {a_ready, b_ready}); end
    total++; if ({a_busy, b_busy} !== 2'b00) begin bad++; $display("FAIL reset_busy: got %b want 00", {a_busy, b_busy}); end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_routing();
    logic [7:0] pat [4] = '{8'hAA, 8'h55, 8'hFF, 8'h00};
    a_or = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      a_data = pat[i]; a_sel = 2'(i); a_valid = 1'b1;
      tick();
      total++; if (a_ov !== 4'(1 << i)) begin bad++; $display("FAIL route_valid%0d: got %b want %b", i, a_ov, 4'(1 << i)); end
      total++; if (a_o[i] !== pat[i]) begin bad++; $display("FAIL route_data%0d: got %h want %h", i, a_o[i], pat[i]); end
    end
    a_valid = 1'b0;
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL route_busy: got %b want 1", a_busy); end
    tick();
    total++; if (a_ov !== 4'b0000) begin bad++; $display("FAIL route_drained: got %b want 0000", a_ov); end
  endtask

  task automatic test_backpressure();
    a_or = 4'b1101;
    a_data = 8'h55; a_sel = 2'd1; a_valid = 1'b1;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL bp_first_ready: got %b want 1", a_ready); end
    tick();
    a_data = 8'h33;
    #1;
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL bp_second_ready: got %b want 0", a_ready); end
    tick();
    total++; if (a_o[1] !== 8'h55 || a_ov[1] !== 1'b1) begin bad++; $display("FAIL bp_hold: got %h/%b want 55/1", a_o[1], a_ov[1]); end
    a_or = 4'b1111;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", a_ready); end
    tick();
    total++; if (a_o[1] !== 8'h33 || a_ov[1] !== 1'b1) begin bad++; $display("FAIL bp_replace: got %h/%b want 33/1", a_o[1], a_ov[1]); end
    a_valid = 1'b0;
    a_or = 4'b1101;
  endtask

  task automatic test_independence();
    a_data = 8'hC3; a_sel = 2'd2; a_valid = 1'b1;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL indep_ready: got %b want 1", a_ready); end
    tick();
    a_valid = 1'b0;
    total++; if (a_o[2] !== 8'hC3 || a_ov !== 4'b0110) begin bad++; $display("FAIL indep_load: got %h/%b want C3/0110", a_o[2], a_ov); end
    total++; if (a_o[1] !== 8'h33) begin bad++; $display("FAIL indep_stalled: got %h want 33", a_o[1]); end
    a_or = 4'b1111;
    tick();
    total++; if (a_ov !== 4'b0000) begin bad++; $display("FAIL indep_drained: got %b want 0000", a_ov); end
  endtask

  task automatic test_round_robin();
    b_or = 4'b1111; b_sel = 2'd3;
    for (int i = 0; i < 5; i++) begin
      b_data = 8'(i + 1); b_valid = 1'b1;
      tick();
      total++; if (b_ov !== 4'(1 << (i % 4)) || b_o[i % 4] !== 8'(i + 1)) begin
        bad++; $display("FAIL rr_word%0d: got %b/%h want %b/%h", i, b_ov, b_o[i % 4], 4'(1 << (i % 4)), 8'(i + 1));
      end
    end
    b_valid = 1'b0;
    total++; if (b_rr !== 2'd1) begin bad++; $display("FAIL rr_end_ptr: got %0d want 1", b_rr); end
    // channel 2 is stalled; 07 parks there and 0B must wait behind it
    b_or = 4'b1011;
    for (int i = 6; i <= 10; i++) begin
      b_data = 8'(i); b_valid = 1'b1;
      tick();
    end
    b_data = 8'h0B;
    #1;
    total++; if (b_ready !== 1'b0 || b_rr !== 2'd2) begin bad++; $display("FAIL rr_stall: got ready=%b ptr=%0d want ready=0 ptr=2", b_ready, b_rr); end
    tick();
    total++; if (b_rr !== 2'd2 || b_o[2] !== 8'h07) begin bad++; $display("FAIL rr_hold: got ptr=%0d d2=%h want ptr=2 d2=07", b_rr, b_o[2]); end
    b_or = 4'b1111;
    #1;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL rr_release_ready: got %b want 1", b_ready); end
    tick();
    b_valid = 1'b0;
    total++; if (b_rr !== 2'd3 || b_o[2] !== 8'h0B || b_ov[2] !== 1'b1) begin
      bad++; $display("FAIL rr_release: got ptr=%0d d2=%h v2=%b want ptr=3 d2=0B v2=1", b_rr, b_o[2], b_ov[2]);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    a_or = 4'b0000; b_or = 4'b0000;
    a_data = 8'h11; a_sel = 2'd0; a_valid = 1'b1;
    b_data = 8'h44; b_valid = 1'b1;
    tick();
    a_data = 8'h22; a_sel = 2'd3; b_valid = 1'b0;
    tick();
    a_valid = 1'b0;
    total++; if (a_ov !== 4'b1001) begin bad++; $display("FAIL mid_full: got %b want 1001", a_ov); end
    total++; if (b_rr !== 2'd0 || b_ov[3] !== 1'b1) begin bad++; $display("FAIL mid_rr_wrap: got ptr=%0d v3=%b want ptr=0 v3=1", b_rr, b_ov[3]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if ({a_ov, b_ov} !== 8'h00) begin bad++; $display("FAIL mid_reset_valid: got %b want 00000000", {a_ov, b_ov}); end
    total++; if (a_o[0] !== 8'h00 || a_o[3] !== 8'h00 || b_rr !== 2'd0) begin
      bad++; $display("FAIL mid_reset_state: got d0=%h d3=%h ptr=%0d want 00 00 0", a_o[0], a_o[3], b_rr);
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_independence();
    test_round_robin();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
